// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
//
// Registered LED pattern engine for the five iCEstick user LEDs. A debounced
// push-button steps through five display modes (STATIC, CHASE, BOUNCE, BLINK,
// COUNT). A prescaler sets the pattern step rate. All outputs come straight
// from flip-flops, so there is no combinational path from btn to the pins.
//
// Ports:
//   clk    in   system clock (12 MHz oscillator)
//   rstn   in   asynchronous active-low reset
//   btn    in   raw push-button, active-high, asynchronous to clk
//   D1..D5 out  LED drives, D1 = pat[0] ... D5 = pat[4]
//   mode   out  current mode index (0..4), for debug and verification
// ---------------------------------------------------------------------------
module led_pattern_sequencer #(
  parameter int DIV        = 3000000,  // clk cycles per pattern step, >= 2
  parameter int DEB_CYCLES = 120000    // stable cycles to accept a level, >= 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       D4,
  output logic       D5,
  output logic [2:0] mode
);

  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DEB_CYCLES);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    MODE_STATIC = 3'd0,
    MODE_CHASE  = 3'd1,
    MODE_BOUNCE = 3'd2,
    MODE_BLINK  = 3'd3,
    MODE_COUNT  = 3'd4
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [4:0] PAT_STATIC = 5'b11011;
  localparam logic [4:0] PAT_CHASE  = 5'b00001;
  localparam logic [4:0] PAT_BOUNCE = 5'b00001;
  localparam logic [4:0] PAT_BLINK  = 5'b11111;
  localparam logic [4:0] PAT_COUNT  = 5'b00000;

  // Mode sequence 0->1->2->3->4->0; anything else falls back to STATIC.
  function automatic logic [2:0] next_mode(input logic [2:0] m);
    case (m)
      MODE_STATIC: next_mode = MODE_CHASE;
      MODE_CHASE:  next_mode = MODE_BOUNCE;
      MODE_BOUNCE: next_mode = MODE_BLINK;
      MODE_BLINK:  next_mode = MODE_COUNT;
      MODE_COUNT:  next_mode = MODE_STATIC;
      default:     next_mode = MODE_STATIC;
    endcase
  endfunction

  // Pattern loaded on entry to a mode.
  function automatic logic [4:0] load_pattern(input logic [2:0] m);
    case (m)
      MODE_STATIC: load_pattern = PAT_STATIC;
      MODE_CHASE:  load_pattern = PAT_CHASE;
      MODE_BOUNCE: load_pattern = PAT_BOUNCE;
      MODE_BLINK:  load_pattern = PAT_BLINK;
      MODE_COUNT:  load_pattern = PAT_COUNT;
      default:     load_pattern = PAT_STATIC;
    endcase
  endfunction

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          btn_meta;
  logic          btn_sync;
  logic          deb_level;
  logic          deb_prev;
  logic [DW-1:0] deb_cnt;
  logic          press;
  logic [4:0]    pat;
  dir_t          dir;
  logic [2:0]    mode_next;
  logic [4:0]    pat_next;
  dir_t          dir_next;

  assign tick  = (pre_cnt == PRE_LAST);
  // Rising edge of the debounced level; the one-cycle delay on deb_prev
  // means a held button yields exactly one event and release yields none.
  assign press = deb_level & ~deb_prev;

  // Step-rate prescaler; a press restarts it so the first step after a
  // mode change lands a full DIV cycles later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt <= '0;
    end else if (press || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // Debouncer: a new level is accepted only after it has differed from the
  // current debounced level for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      deb_prev <= deb_level;
      if (btn_sync != deb_level) begin
        if (deb_cnt == DEB_LAST) begin
          deb_level <= btn_sync;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Mode / pattern / direction next-state logic. Priority: illegal mode
  // recovery, then press (which swallows a coincident tick), then tick.
  always_comb begin
    mode_next = mode;
    pat_next  = pat;
    dir_next  = dir;
    if (mode > MODE_COUNT) begin
      mode_next = MODE_STATIC;
      pat_next  = PAT_STATIC;
      dir_next  = DIR_UP;
    end else if (press) begin
      mode_next = next_mode(mode);
      pat_next  = load_pattern(next_mode(mode));
      dir_next  = DIR_UP;
    end else if (tick) begin
      case (mode)
        MODE_CHASE: begin
          pat_next = {pat[3:0], pat[4]};
        end
        MODE_BOUNCE: begin
          // Turn around at each end so each end is shown for one tick.
          if (dir == DIR_UP) begin
            if (pat == 5'b10000) begin
              dir_next = DIR_DOWN;
              pat_next = 5'b01000;
            end else begin
              pat_next = {pat[3:0], 1'b0};
            end
          end else begin
            if (pat == 5'b00001) begin
              dir_next = DIR_UP;
              pat_next = 5'b00010;
            end else begin
              pat_next = {1'b0, pat[4:1]};
            end
          end
        end
        MODE_BLINK: begin
          pat_next = ~pat;
        end
        MODE_COUNT: begin
          pat_next = pat + 5'd1;
        end
        default: begin
          pat_next = pat;
        end
      endcase
    end else begin
      pat_next = pat;
    end
  end

  // Mode / pattern / direction state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode <= MODE_STATIC;
      pat  <= PAT_STATIC;
      dir  <= DIR_UP;
    end else begin
      mode <= mode_next;
      pat  <= pat_next;
      dir  <= dir_next;
    end
  end

  assign D1 = pat[0];
  assign D2 = pat[1];
  assign D3 = pat[2];
  assign D4 = pat[3];
  assign D5 = pat[4];

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for led_pattern_sequencer (DIV=4, DEB_CYCLES=8).
// A behavioural model tracks button filtering and the pattern as a function
// of (mode, steps since load); every cycle the LEDs and mode are compared
// against it, plus directed checks of the tick sequences for each mode.
// ---------------------------------------------------------------------------
module tb_led_pattern_sequencer;

  localparam int DIV = 4;
  localparam int DEB = 8;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       btn  = 1'b0;
  logic       D1, D2, D3, D4, D5;
  logic [2:0] mode;

  led_pattern_sequencer #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .btn  (btn),
    .D1   (D1),
    .D2   (D2),
    .D3   (D3),
    .D4   (D4),
    .D5   (D5),
    .mode (mode)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_mode, m_k, m_phase, m_run;
  bit m_s1, m_s2, m_deb, m_deb_d;
  bit m_press_last, m_tick_last;
  int hold_cnt = 0;
  logic [4:0] cap[$];

  localparam logic [4:0] CHASE_EXP [5] =
    '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
  localparam logic [4:0] BOUNCE_EXP [9] =
    '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
      5'b00100, 5'b00010, 5'b00001, 5'b00010};

  function automatic logic [4:0] led_word();
    return {D5, D4, D3, D2, D1};
  endfunction

  // Pattern after k steps in mode md, straight from the mode descriptions.
  function automatic logic [4:0] exp_pat(input int md, input int k);
    int pos;
    case (md)
      1: exp_pat = 5'b00001 << (k % 5);
      2: begin
        pos = k % 8;
        if (pos > 4) pos = 8 - pos;
        exp_pat = 5'b00001 << pos;
      end
      3: exp_pat = ((k % 2) == 0) ? 5'b11111 : 5'b00000;
      4: exp_pat = 5'(k % 32);
      default: exp_pat = 5'b11011;
    endcase
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_k = 0; m_phase = 0; m_run = 0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_deb = 1'b0; m_deb_d = 1'b0;
    m_press_last = 1'b0; m_tick_last = 1'b0;
  endfunction

  // One rising edge of the model; all decisions use pre-edge values.
  function automatic void model_edge();
    bit pr, tk;
    pr = m_deb && !m_deb_d;
    tk = (m_phase % DIV) == (DIV - 1);
    if (pr) begin
      m_mode = (m_mode + 1) % 5;
      m_k = 0;
      m_phase = 0;
    end else begin
      if (tk) m_k++;
      m_phase++;
    end
    m_deb_d = m_deb;
    if (m_s2 != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
    m_press_last = pr;
    m_tick_last = tk && !pr;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("cyc_pat", 8'(led_word()), 8'(exp_pat(m_mode, m_k)));
    chk("cyc_mode", 8'(mode), 8'(m_mode));
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) btn = 1'b0;
    end
  endtask

  // Let any held button finish and the debouncer return to idle.
  task automatic settle();
    while (hold_cnt > 0) cyc();
    repeat (14) cyc();
  endtask

  // Hold the button for 20 cycles and wait for the model's press event.
  task automatic press(input bit align);
    bit seen;
    settle();
    if (align) begin
      // Press lands 10 edges after the first high sample; pick a start so
      // that edge is also a prescaler tick.
      while ((m_phase % DIV) != 1) cyc();
    end
    btn = 1'b1;
    hold_cnt = 20;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      seen = m_press_last;
    end
    chk("press_seen", 8'(seen), 8'd1);
  endtask

  task automatic wait_ticks(input int n);
    int got;
    cap.delete();
    got = 0;
    for (int i = 0; i < (n + 2) * DIV && got < n; i++) begin
      cyc();
      if (m_tick_last && m_mode != 0) begin
        cap.push_back(led_word());
        got++;
      end
    end
    chk("ticks_seen", 8'(got), 8'(n));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;

    // 1: STATIC ignores ticks
    repeat (100) cyc();
    chk("t1_leds", 8'(led_word()), 8'(5'b11011));
    chk("t1_mode", 8'(mode), 8'd0);

    // 2: enter CHASE, five ticks, release causes nothing
    press(1'b0);
    chk("t2_mode", 8'(mode), 8'd1);
    chk("t2_load", 8'(led_word()), 8'(5'b00001));
    wait_ticks(5);
    for (int i = 0; i < 5; i++) chk("t2_chase_seq", 8'(cap[i]), 8'(CHASE_EXP[i]));
    settle();
    chk("t2_release", 8'(mode), 8'd1);

    // 3: short pulses are rejected
    btn = 1'b1; hold_cnt = 5;
    repeat (25) cyc();
    btn = 1'b1; hold_cnt = 7;
    repeat (27) cyc();
    chk("t3_mode", 8'(mode), 8'd1);

    // 4: BOUNCE
    press(1'b0);
    chk("t4_mode", 8'(mode), 8'd2);
    chk("t4_load", 8'(led_word()), 8'(5'b00001));
    wait_ticks(9);
    for (int i = 0; i < 9; i++) chk("t4_bounce_seq", 8'(cap[i]), 8'(BOUNCE_EXP[i]));

    // 5: BLINK, then COUNT wrap, then press coinciding with a tick
    press(1'b0);
    chk("t5_blink_load", 8'(led_word()), 8'(5'b11111));
    wait_ticks(2);
    chk("t5_blink0", 8'(cap[0]), 8'(5'b00000));
    chk("t5_blink1", 8'(cap[1]), 8'(5'b11111));
    press(1'b0);
    chk("t5_count_mode", 8'(mode), 8'd4);
    chk("t5_count_load", 8'(led_word()), 8'(5'b00000));
    wait_ticks(31);
    chk("t5_count31", 8'(led_word()), 8'(5'b11111));
    wait_ticks(1);
    chk("t5_count32", 8'(led_word()), 8'(5'b00000));
    press(1'b1);
    chk("t5_coinc_mode", 8'(mode), 8'd0);
    chk("t5_coinc_leds", 8'(led_word()), 8'(5'b11011));

    // 6: asynchronous reset in the middle of CHASE
    press(1'b0);
    chk("t6_mode", 8'(mode), 8'd1);
    settle();
    @(posedge clk);
    model_edge();
    #3 rstn = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_leds", 8'(led_word()), 8'(5'b11011));
    chk("t6_rst_mode", 8'(mode), 8'd0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    repeat (4) begin
      cyc();
      chk("t6_post_rst", 8'(led_word()), 8'(5'b11011));
    end
    press(1'b0);
    wait_ticks(1);
    chk("t6_chase_step", 8'(cap[0]), 8'(5'b00010));

    // Randomised button activity against the model
    settle();
    repeat (60) begin
      btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
